// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared constants, types and helpers for the fetch stage
// Revision 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_e;

  // J-type target: region bits of the delay-slot PC plus the word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// fetch_stage_if_id_reg : IF/ID pipeline register with hold, flush and load
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_stage_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Hold outranks flush so a stalled ID instruction is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      if (i_flush) begin
        r_instr    <= NOP_INSTR;
        r_pc_plus4 <= 32'd0;
        r_valid    <= 1'b0;
      end else begin
        r_instr    <= i_instr;
        r_pc_plus4 <= i_pc_plus4;
        r_valid    <= 1'b1;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC register, next-PC selection and IF/ID register for MIPS
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic        pc_jump,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic        redirect
);

  import fetch_stage_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_next;
  logic        w_rdir;
  logic        w_flush;
  pc_sel_e     w_pc_sel;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_jump_target = jump_target(if_id_pc_plus4, if_id_instr);
  // A bubble in ID can never redirect, whatever the controller drives.
  assign w_rdir        = if_id_valid & ~stall & (pc_jump | pc_src);
  assign w_flush       = w_rdir | ~imem_ready;

  always_comb begin
    w_pc_sel = PC_HOLD;
    if (stall) begin
      w_pc_sel = PC_HOLD;
    end else if (w_rdir) begin
      w_pc_sel = pc_jump ? PC_JUMP : PC_BRANCH;
    end else if (imem_ready) begin
      w_pc_sel = PC_SEQ;
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_pc_sel)
      PC_SEQ:    w_pc_next = w_pc_plus4;
      PC_JUMP:   w_pc_next = w_jump_target;
      PC_BRANCH: w_pc_next = branch_target;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (stall),
    .i_flush    (w_flush),
    .i_instr    (imem_rdata),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign imem_addr = r_pc;
  assign redirect  = w_rdir;
  assign opcode    = if_id_instr[OPC_MSB:OPC_LSB];
  assign rs        = if_id_instr[25:21];
  assign rt        = if_id_instr[20:16];
  assign rd        = if_id_instr[15:11];
  assign imm       = if_id_instr[15:0];
  assign func      = if_id_instr[5:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed vector bench for fetch_stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_src;
  logic        pc_jump;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        redirect;

  int n_checks;
  int n_fail;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pc_src         (pc_src),
    .pc_jump        (pc_jump),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .opcode         (opcode),
    .func           (func),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .imm            (imm),
    .redirect       (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;  // addi $t0,$0,5
      32'h0000_0004: return 32'h0800_0010;  // j 0x40
      32'h0000_0040: return 32'h1000_0003;  // beq
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic        pc_jump;
    logic        ready;
    logic [31:0] bt;
    logic        exp_rdir;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic s, input logic ps, input logic pj,
                              input logic rdy, input logic [31:0] bt,
                              input logic er, input logic [31:0] epc,
                              input logic [31:0] ei, input logic [31:0] ep4,
                              input logic ev);
    vec_t v;
    v.stall = s; v.pc_src = ps; v.pc_jump = pj; v.ready = rdy; v.bt = bt;
    v.exp_rdir = er; v.exp_pc = epc; v.exp_instr = ei; v.exp_pc4 = ep4;
    v.exp_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc,
                             input logic [31:0] ei, input logic [31:0] ep4,
                             input logic ev);
    check({tag, " pc"}, imem_addr, epc);
    check({tag, " instr"}, if_id_instr, ei);
    check({tag, " pc_plus4"}, if_id_pc_plus4, ep4);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    check({tag, " fields"}, {opcode, rs, rt, imm},
          {ei[31:26], ei[25:21], ei[20:16], ei[15:0]});
    check({tag, " func/rd"}, {21'd0, rd, func}, {21'd0, ei[15:11], ei[5:0]});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            stl ps pj rdy bt             rdir pc             instr          pc4            v
    vecs[0]  = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1);
    vecs[1]  = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0008, 32'h0800_0010, 32'h0000_0008, 1);
    vecs[2]  = mk(0, 0, 1, 1, 32'h0,          1, 32'h0000_0040, 32'h0,         32'h0,         0);
    vecs[3]  = mk(0, 0, 1, 1, 32'h0,          0, 32'h0000_0044, 32'h1000_0003, 32'h0000_0044, 1);
    vecs[4]  = mk(1, 1, 0, 1, 32'h100,        0, 32'h0000_0044, 32'h1000_0003, 32'h0000_0044, 1);
    vecs[5]  = mk(1, 1, 0, 1, 32'h100,        0, 32'h0000_0044, 32'h1000_0003, 32'h0000_0044, 1);
    vecs[6]  = mk(0, 1, 0, 1, 32'h100,        1, 32'h0000_0100, 32'h0,         32'h0,         0);
    vecs[7]  = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0104, 32'hC0DE_0100, 32'h0000_0104, 1);
    vecs[8]  = mk(0, 1, 0, 1, 32'h20,         1, 32'h0000_0020, 32'h0,         32'h0,         0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,          0, 32'h0000_0020, 32'h0,         32'h0,         0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,          0, 32'h0000_0020, 32'h0,         32'h0,         0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,          0, 32'h0000_0020, 32'h0,         32'h0,         0);
    vecs[12] = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0024, 32'hC0DE_0020, 32'h0000_0024, 1);
    vecs[13] = mk(0, 1, 0, 0, 32'h80,         1, 32'h0000_0080, 32'h0,         32'h0,         0);
    vecs[14] = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0084, 32'hC0DE_0080, 32'h0000_0084, 1);
    vecs[15] = mk(0, 1, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    vecs[16] = mk(0, 0, 0, 1, 32'h0,          0, 32'h0000_0000, 32'hC0DE_FFFC, 32'h0000_0000, 1);
    vecs[17] = mk(0, 1, 1, 1, 32'h200,        1, 32'h037B_FFF0, 32'h0,         32'h0,         0);

    rst_n         = 1'b0;
    stall         = 1'b0;
    pc_src        = 1'b0;
    pc_jump       = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset redirect", {31'd0, redirect}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      stall         = vecs[i].stall;
      pc_src        = vecs[i].pc_src;
      pc_jump       = vecs[i].pc_jump;
      imem_ready    = vecs[i].ready;
      branch_target = vecs[i].bt;
      #1;
      check($sformatf("v%0d redirect", i), {31'd0, redirect},
            {31'd0, vecs[i].exp_rdir});
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                  vecs[i].exp_pc4, vecs[i].exp_valid);
    end

    // Asynchronous reset asserted mid-cycle while a stalled redirect is pending.
    stall   = 1'b1;
    pc_src  = 1'b1;
    pc_jump = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("async reset redirect", {31'd0, redirect}, 32'd0);
    stall      = 1'b0;
    pc_src     = 1'b0;
    imem_ready = 1'b1;
    #1;
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    check_state("post-reset fetch0", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    check("post-reset opcode", {26'd0, opcode}, {26'd0, 6'b001000});
    check("post-reset rt", {27'd0, rt}, 32'd8);
    check("post-reset imm", {16'd0, imm}, 32'd5);
    @(posedge clk);
    #1;
    check_state("post-reset fetch1", 32'h8, 32'h0800_0010, 32'h8, 1'b1);
    @(posedge clk);
    #1;
    check_state("post-reset fetch2", 32'hC, 32'hC0DE_0008, 32'hC, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
